// File: rtl/kan_pkg.sv
// kan_pkg: shared FSM encoding, weight-select codes and output clamping helpers
package kan_pkg;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    localparam logic WSEL_BASE   = 1'b0;
    localparam logic WSEL_SPLINE = 1'b1;
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
    function automatic logic signed [63:0] relu(input logic signed [63:0] v, input logic en);
        return (en && v < 64'sd0) ? 64'sd0 : v;
    endfunction
endpackage

// File: rtl/kan_mac_unit.sv
// kan_mac_unit: accumulates one base + hinge term per cycle and presents the clamped readout
module kan_mac_unit
    import kan_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int OUT_RELU = 1,
    parameter int ACC_W    = 2*DATA_W + 3
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [DATA_W-1:0] i_base_w,
    input  logic signed [DATA_W-1:0] i_spline_w,
    input  logic                     i_acc_clr,
    input  logic                     i_acc_en,
    output logic        [DATA_W-1:0] o_result
);
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [DATA_W-1:0]   w_x_pos;
    logic signed [2*DATA_W-1:0] w_base_p, w_spline_p;
    logic signed [ACC_W-1:0]    w_sum, w_shift;

    // term = base*x + spline*max(x,0); readout includes the current term so the last one is not lost
    always_comb begin
        w_x_pos    = i_x[DATA_W-1] ? '0 : i_x;
        w_base_p   = i_base_w * i_x;
        w_spline_p = i_spline_w * w_x_pos;
        w_sum      = r_acc + ACC_W'(w_base_p) + ACC_W'(w_spline_p);
        w_shift    = w_sum >>> FRAC_W;
        o_result   = DATA_W'(relu(sat_to_width(64'(w_shift), DATA_W), OUT_RELU != 0));
    end

    // accumulator: clear has priority so the finishing cycle starts the next output from zero
    always_ff @(posedge clk)
        r_acc <= (reset || i_acc_clr) ? '0 : i_acc_en ? w_sum : r_acc;
endmodule

// File: rtl/kan_linear_seq.sv
// kan_linear_seq: time-multiplexed KAN linear layer with handshaked vectors and loadable weights
module kan_linear_seq
    import kan_pkg::*;
#(
    parameter int IN_FEATURES  = 2,
    parameter int OUT_FEATURES = 3,
    parameter int DATA_W       = 16,
    parameter int FRAC_W       = 8,
    parameter int OUT_RELU     = 1,
    parameter int ACC_W        = 2*DATA_W + $clog2(2*IN_FEATURES) + 1
)(
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [IN_FEATURES*DATA_W-1:0]              in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_FEATURES*DATA_W-1:0]             out_data,
    input  logic                                       wr_en,
    input  logic                                       wr_sel,
    input  logic [$clog2(OUT_FEATURES*IN_FEATURES)-1:0] wr_addr,
    input  logic [DATA_W-1:0]                          wr_data,
    output logic                                       busy
);
    localparam int N  = OUT_FEATURES * IN_FEATURES;
    localparam int IW = OUT_FEATURES > 1 ? $clog2(OUT_FEATURES) : 1;
    localparam int JW = IN_FEATURES > 1 ? $clog2(IN_FEATURES) : 1;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(OUT_FEATURES - 1);
    localparam logic [JW-1:0] J_LAST = JW'(IN_FEATURES - 1);

    state_t            r_state, w_next;
    logic [IW-1:0]     r_i;
    logic [JW-1:0]     r_j;
    logic [KW-1:0]     r_k;
    logic [DATA_W-1:0] r_x [IN_FEATURES];
    logic [DATA_W-1:0] r_y [OUT_FEATURES];
    logic [DATA_W-1:0] r_base_w [N];
    logic [DATA_W-1:0] r_spline_w [N];
    logic              w_last_j, w_take, w_wr;
    logic [DATA_W-1:0] w_result;

    assign w_last_j = r_j == J_LAST;
    assign w_take   = r_state == IDLE && in_valid;
    assign w_wr     = wr_en && r_state == IDLE && int'(wr_addr) < N;

    // state register
    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;

    // next state; handshake outputs decode from registered state only
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (w_last_j && r_i == I_LAST) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // weight RAMs: written only while idle, deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (w_wr && wr_sel == WSEL_BASE) r_base_w[wr_addr] <= wr_data;
        if (w_wr && wr_sel == WSEL_SPLINE) r_spline_w[wr_addr] <= wr_data;
    end

    // vector capture, (i,j) walk with j fastest, and per-output writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
            for (int n = 0; n < OUT_FEATURES; n++) r_y[n] <= '0;
        end else if (w_take) begin
            for (int n = 0; n < IN_FEATURES; n++) r_x[n] <= in_data[n*DATA_W +: DATA_W];
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (r_state == MAC) begin
            r_k <= r_k + KW'(1);
            r_j <= w_last_j ? '0 : r_j + JW'(1);
            if (w_last_j) begin
                r_y[r_i] <= w_result;
                r_i      <= r_i + IW'(1);
            end
        end
    end

    // flatten the output registers onto the port
    always_comb begin
        out_data = '0;
        for (int n = 0; n < OUT_FEATURES; n++) out_data[n*DATA_W +: DATA_W] = r_y[n];
    end

    kan_mac_unit #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .OUT_RELU (OUT_RELU),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .i_x        (r_x[r_j]),
        .i_base_w   (r_base_w[r_k]),
        .i_spline_w (r_spline_w[r_k]),
        .i_acc_clr  (r_state != MAC || w_last_j),
        .i_acc_en   (r_state == MAC),
        .o_result   (w_result)
    );
endmodule

// File: tb/tb_kan_linear_seq.sv
// tb_kan_linear_seq: scenario tasks against an arithmetic reference model, ReLU and non-ReLU instances
module tb_kan_linear_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, wr_en = 1'b0, wr_sel = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        in_ready, out_valid, busy, in_ready0, out_valid0, busy0;
    logic [47:0] out_data, out_data0;
    int          chk = 0, err = 0;
    logic signed [15:0] m_base [6];
    logic signed [15:0] m_spl [6];
    logic [47:0] e1, e0;

    always #5 clk = ~clk;

    kan_linear_seq #(.OUT_RELU(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    kan_linear_seq #(.OUT_RELU(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0)
    );

    function automatic logic [15:0] model_y(input int i, input logic [31:0] x, input bit relu);
        longint s = 0;
        for (int j = 0; j < 2; j++) begin
            longint xv = longint'($signed(x[j*16 +: 16]));
            s += longint'(m_base[i*2+j]) * xv + longint'(m_spl[i*2+j]) * (xv < 0 ? 64'sd0 : xv);
        end
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s[15:0];
    endfunction

    task automatic expect_for(input logic [31:0] x);
        for (int i = 0; i < 3; i++) begin
            e1[i*16 +: 16] = model_y(i, x, 1'b1);
            e0[i*16 +: 16] = model_y(i, x, 1'b0);
        end
    endtask

    task automatic model_write(input bit sel, input int addr, input logic [15:0] wd);
        if (addr < 6) begin
            if (sel) m_spl[addr] = wd;
            else m_base[addr] = wd;
        end
    endtask

    task automatic write_w(input bit sel, input int addr, input logic [15:0] wd);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr[2:0]; wr_data = wd;
        model_write(sel, addr, wd);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] bw, input logic [15:0] sw);
        for (int k = 0; k < 6; k++) begin
            write_w(1'b0, k, bw);
            write_w(1'b1, k, sw);
        end
    endtask

    task automatic run_vec(input string nm, input logic [31:0] x, input bit wr_same, input bit wr_mid,
                           input bit sel, input int addr, input logic [15:0] wd);
        int lat;
        @(negedge clk);
        chk++;
        if (in_ready !== 1'b1) begin err++; $display("FAIL %s_ready: got %b expected 1", nm, in_ready); end
        in_data = x; in_valid = 1'b1;
        wr_en = wr_same; wr_sel = sel; wr_addr = addr[2:0]; wr_data = wd;
        if (wr_same) model_write(sel, addr, wd);
        expect_for(x);
        @(negedge clk);
        in_valid = 1'b0; in_data = $urandom;
        wr_en = wr_mid;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            wr_en = 1'b0;
            lat++;
        end
        wr_en = 1'b0;
        chk++;
        if (lat != 7) begin err++; $display("FAIL %s_latency: got %0d expected 7", nm, lat); end
        chk++;
        if (out_data !== e1) begin err++; $display("FAIL %s_relu1: got %h expected %h", nm, out_data, e1); end
        chk++;
        if (out_data0 !== e0) begin err++; $display("FAIL %s_relu0: got %h expected %h", nm, out_data0, e0); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk++;
        if ({in_ready, out_valid} !== 2'b10) begin
            err++; $display("FAIL %s_release: got %b expected 10", nm, {in_ready, out_valid});
        end
    endtask

    task automatic run(input string nm, input logic [31:0] x);
        run_vec(nm, x, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            err++; $display("FAIL reset_ctrl: got %b expected 100", {in_ready, out_valid, busy});
        end
        chk++;
        if (out_data !== 48'h0) begin err++; $display("FAIL reset_data: got %h expected 0", out_data); end
        chk++;
        if ({in_ready0, out_valid0, busy0, out_data0} !== {3'b100, 48'h0}) begin
            err++; $display("FAIL reset_dut0: got %b/%h expected 100/0", {in_ready0, out_valid0, busy0}, out_data0);
        end
    endtask

    task automatic test_basic;
        set_all(16'h0100, 16'h0000);
        run("basic", {16'h0100, 16'h0200});
        chk++;
        if (out_data !== {3{16'h0300}}) begin err++; $display("FAIL basic_hold: got %h expected %h", out_data, {3{16'h0300}}); end
    endtask

    task automatic test_spline;
        set_all(16'h0000, 16'h0100);
        run("hinge", {16'h0080, 16'hFF00});
        chk++;
        if ({out_data, out_data0} !== {{3{16'h0080}}, {3{16'h0080}}}) begin
            err++; $display("FAIL hinge_const: got %h/%h expected 0080s", out_data, out_data0);
        end
        set_all(16'h0100, 16'h0000);
        run("neg", {16'h0080, 16'hFF00});
        chk++;
        if ({out_data, out_data0} !== {48'h0, {3{16'hFF80}}}) begin
            err++; $display("FAIL neg_const: got %h/%h expected 0/ff80s", out_data, out_data0);
        end
    endtask

    task automatic test_saturation;
        set_all(16'h7FFF, 16'h0000);
        run("sat_pos", {16'h7FFF, 16'h7FFF});
        chk++;
        if ({out_data, out_data0} !== {{3{16'h7FFF}}, {3{16'h7FFF}}}) begin
            err++; $display("FAIL sat_pos_const: got %h/%h expected 7fffs", out_data, out_data0);
        end
        set_all(16'h8001, 16'h0000);
        run("sat_neg", {16'h7FFF, 16'h7FFF});
        chk++;
        if ({out_data, out_data0} !== {48'h0, {3{16'h8000}}}) begin
            err++; $display("FAIL sat_neg_const: got %h/%h expected 0/8000s", out_data, out_data0);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [47:0] hold;
        set_all(16'h0180, 16'hFF40);
        @(negedge clk);
        in_data = {16'h0300, 16'h0140}; in_valid = 1'b1;
        expect_for(in_data);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        hold = out_data;
        chk++;
        if (hold !== e1) begin err++; $display("FAIL bp_data: got %h expected %h", hold, e1); end
        in_valid = 1'b1; in_data = 32'h1234_5678;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk++;
            if ({out_valid, in_ready, out_data} !== {2'b10, hold}) begin
                err++; $display("FAIL bp_hold: got %b/%h expected 10/%h", {out_valid, in_ready}, out_data, hold);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk++;
        if ({in_ready, out_valid} !== 2'b10) begin err++; $display("FAIL bp_release: got %b expected 10", {in_ready, out_valid}); end
        @(negedge clk);
        chk++;
        if ({busy, out_data} !== {1'b0, hold}) begin err++; $display("FAIL bp_no_second: got %b/%h expected 0/%h", busy, out_data, hold); end
    endtask

    task automatic test_weight_writes;
        for (int k = 0; k < 6; k++) begin
            write_w(1'b0, k, 16'(16'h0040 * (k + 1)));
            write_w(1'b1, k, 16'(16'h0100 - 16'h0030 * k));
        end
        run_vec("wr_busy", {16'h0200, 16'hFE80}, 1'b0, 1'b1, 1'b0, 0, 16'h7FFF);
        run("wr_busy_next", {16'h0200, 16'hFE80});
        run_vec("wr_same", {16'h0200, 16'hFE80}, 1'b1, 1'b0, 1'b1, 3, 16'h0400);
        write_w(1'b0, 6, 16'h7000);
        run("wr_oob", {16'h0200, 16'hFE80});
    endtask

    task automatic test_reset_mid;
        set_all(16'h0100, 16'h0040);
        @(negedge clk);
        in_data = {16'h0100, 16'h0300}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk++;
        if (busy !== 1'b1) begin err++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk++;
        if ({in_ready, out_valid, busy, out_data} !== {3'b100, 48'h0}) begin
            err++; $display("FAIL mid_reset: got %b/%h expected 100/0", {in_ready, out_valid, busy}, out_data);
        end
        run("mid_weights_kept", {16'hFF40, 16'h0280});
    endtask

    task automatic test_back_to_back;
        int n;
        for (int k = 0; k < 6; k++) begin
            write_w(1'b0, k, 16'($urandom_range(0, 16'h03FF)));
            write_w(1'b1, k, 16'($urandom_range(0, 16'h03FF)));
        end
        @(negedge clk);
        in_data = $urandom; in_valid = 1'b1; out_ready = 1'b1;
        expect_for(in_data);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk++;
        if (out_data !== e1) begin err++; $display("FAIL b2b_data: got %h expected %h", out_data, e1); end
        n = 0;
        @(negedge clk); n++;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        chk++;
        if (n != 8) begin err++; $display("FAIL b2b_interval: got %0d expected 8", n); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 6; k++) begin
                write_w(1'b0, k, 16'($urandom));
                write_w(1'b1, k, 16'($urandom));
            end
            run("random", $urandom);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_spline;
        test_saturation;
        test_backpressure;
        test_weight_writes;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule

// File: doc/kan_linear_seq.md
Name: kan_linear_seq

Overview:
- Time-multiplexed, handshaked successor to the combinational KAN linear layer.
- Computes OUT_FEATURES signed fixed-point outputs from IN_FEATURES inputs using one shared MAC datapath, iterating over all (out, in) pairs.
- Each term is a base path plus a spline path approximated by a ReLU hinge; weights are runtime-loadable.
- Adds output saturation and optional output ReLU.
- Sits between layers in the KAN chain, one instance per layer.

Parameters:
- IN_FEATURES, 2, input vector length (>=1)
- OUT_FEATURES, 3, output vector length (>=1)
- DATA_W, 16, width of data and weights, signed two's complement
- FRAC_W, 8, fractional bits of data and weights (Q(DATA_W-FRAC_W).FRAC_W)
- OUT_RELU, 1, 1 = clamp negative outputs to 0 after saturation
- ACC_W, 2*DATA_W+$clog2(2*IN_FEATURES)+1, accumulator width (derived; do not override)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  IN_FEATURES*DATA_W  flattened inputs, x[j] at bits [j*DATA_W +: DATA_W]
- out_valid  out  1  output vector valid
- out_ready  in  1  consumer accepts output
- out_data  out  OUT_FEATURES*DATA_W  flattened outputs, y[i] at [i*DATA_W +: DATA_W]
- wr_en  in  1  weight write strobe
- wr_sel  in  1  0 = base weight, 1 = spline weight
- wr_addr  in  $clog2(OUT_FEATURES*IN_FEATURES)  weight index i*IN_FEATURES+j
- wr_data  in  DATA_W  signed weight value
- busy  out  1  high in MAC or DONE

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, busy=0, state=IDLE.
  - Weight memories are NOT cleared by reset.
  - Reset mid-operation aborts the computation and drops the captured vector.
- Function: y[i] = sat( (sum_j base_w[i][j]*x[j] + spline_w[i][j]*max(x[j],0)) >>> FRAC_W ).
  - All operands are signed.
  - Products are full 2*DATA_W wide and summed in an ACC_W accumulator with no intermediate overflow.
  - Shift is arithmetic, truncating toward -inf.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If OUT_RELU=1, negative results become 0 after saturation.
- FSM states: IDLE, MAC, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the internal x register, clear the accumulator, set i=0, j=0, and go to MAC.
  - MAC: one (i,j) term added per cycle, j fastest. On j==IN_FEATURES-1, the finished y[i] is saturated and written into the out_data register, the accumulator is cleared, j is set to 0, and i is incremented. After the i==OUT_FEATURES-1 write, go to DONE.
  - DONE: out_valid=1 and out_data is stable. On out_ready, drop out_valid, raise in_ready, and go to IDLE.
  - out_data holds its last value while in IDLE.
- Latency: input handshake cycle -> out_valid asserted exactly OUT_FEATURES*IN_FEATURES+1 cycles later.
- Throughput: one vector per OUT_FEATURES*IN_FEATURES+2 cycles when out_ready is held high.
- in_data changes after capture have no effect on the result.
- Weight writes:
  - Applied at the clock edge when wr_en=1 and state==IDLE.
  - Writes while busy=1 are dropped with no effect.
  - A write and an input handshake in the same IDLE cycle: the write takes effect first, so the new vector uses the new weight.
  - wr_addr >= OUT_FEATURES*IN_FEATURES is ignored.
- No combinational path from in_valid or out_ready to any output other than through registered state.

Decomposition:
- Package kan_pkg:
  - state enum (IDLE, MAC, DONE).
  - sat_to_width and relu helper functions.
  - WSEL_BASE/WSEL_SPLINE constants.
- Sub-module kan_mac_unit (natural):
  - Inputs: x, base_w, spline_w, acc_clr, acc_en.
  - Outputs: the registered accumulator and the saturated/ReLU'd result.
- Top level holds the FSM, counters, weight RAMs and the x/out registers.

Test Plan:
- Reset: assert reset for 2 cycles mid-MAC -> next cycle in_ready=1, out_valid=0, out_data=0, busy=0; previously written weights are still intact.
- Basic, defaults, FRAC_W=8: base_w all 0x0100 (1.0), spline_w all 0; x={0x0200,0x0100} -> every y=0x0300, out_valid exactly 7 cycles after the handshake.
- Spline hinge: base_w=0, spline_w=0x0100.
  - x={0xFF00,0x0080} (-1.0, 0.5) -> all y=0x0080.
  - OUT_RELU=0 with base_w=0x0100 -> y=0xFF80.
- Saturation: base_w=0x7FFF, x={0x7FFF,0x7FFF} -> y=0x7FFF. Negate the weights with OUT_RELU=0 -> y=0x8000; with OUT_RELU=1 -> y=0x0000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, a second in_valid is not accepted; release -> returns to IDLE next cycle.
- Weight-write rules: wr_en during MAC -> no change to the current or next result; write in the same cycle as the input handshake -> the result reflects the new weight; wr_addr=6 (out of range) -> no change.
